sdma_mc_capture: RTL and testbench
==================================

// Module: sdma_mc_capture
// PURPOSE
//  Multi-channel, triggered ping-pong capture buffer for the SDMA acquisition path.
//  Each frame stores DEPTH samples per channel from the ADC front end into a write bank,
//  then swaps banks so the MCU (via the FSMC bridge) reads a stable frame while the next fills.
//  Parametrised successor of the single-channel dual buffer; adds trigger modes, claim/release
//  ownership, overrun counting, frame IDs and abort.
// PARAMETERS
//  DATA_WIDTH   12    ADC sample width per channel
//  DEPTH        1024  samples per channel per frame; power of two, >=4
//  CHANNELS     2     channel count, 1..8
// PORTS
//  clk          in   1                      system clock, single domain
//  rst          in   1                      synchronous reset, active-high
//  sample_en    in   1                      one-cycle strobe per ADC sample (from adc_clk divider)
//  adc_data     in   CHANNELS*DATA_WIDTH    channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  trig_in      in   1                      trigger signal (signal_in), synchronous to clk
//  trig_mode    in   2                      0 free-run, 1 rising, 2 falling, 3 both edges
//  arm          in   1                      pulse: start continuous acquisition from IDLE
//  abort        in   1                      pulse: drop partial frame, go IDLE
//  host_claim   in   1                      pulse: host takes ownership of ready read bank
//  host_release in   1                      pulse: host done; frees read bank
//  rd_en        in   1                      read request
//  rd_addr      in   $clog2(CHANNELS)+$clog2(DEPTH)  {channel, sample index}; CHANNELS=1 -> index only
//  rd_data      out  DATA_WIDTH             read bank data, registered
//  rd_valid     out  1                      high one cycle after rd_en
//  buf_ready    out  1                      complete unread/held frame in read bank
//  claimed      out  1                      host owns read bank
//  capturing    out  1                      FSM in CAPTURE
//  frame_id     out  16                     increments on each successful swap, wraps
//  overrun_cnt  out  16                     lost frames, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, write bank 0 (read bank 1), write_ptr 0, trig_prev 0. RAM not cleared.
//  - FSM IDLE -> (arm) WAIT_TRIG, latching trig_mode. Mode 0 goes straight to CAPTURE.
//  - WAIT_TRIG: edge = trig_in vs registered trig_prev; a qualifying edge moves to CAPTURE next cycle.
//    trig_prev updates every clk. Edges while in CAPTURE/SWAP are ignored.
//  - CAPTURE: on each sample_en, write all channels at write_ptr into the write bank, then ptr++.
//    The write at ptr=DEPTH-1 -> SWAP, ptr wraps to 0.
//  - SWAP (one cycle): if !claimed, toggle banks and frame_id++; if buf_ready was already 1,
//    overrun_cnt++ (stale frame replaced); buf_ready<=1. If claimed, no swap, overrun_cnt++,
//    and the frame is discarded. Then return to WAIT_TRIG (mode 0: straight to CAPTURE), re-latching trig_mode.
//  - host_claim honoured only when buf_ready=1 && !claimed; otherwise ignored.
//    host_release clears claimed and buf_ready; ignored if !claimed.
//  - Same cycle release+SWAP: release applied first, so the swap succeeds and buf_ready stays 1.
//    Same cycle claim+SWAP: the claim wins, so the swap is refused and counted.
//  - Read: rd_en at cycle N -> rd_data/rd_valid at N+1 from current read bank. Channel index
//    >=CHANNELS returns 0. Reads are legal in any state; reading an unclaimed bank may race a swap.
//  - abort (any state): -> IDLE next cycle, ptr 0, partial frame lost (not counted);
//    read bank, claimed, buf_ready, frame_id are untouched. abort beats arm in the same cycle.
//  - arm outside IDLE ignored. sample_en outside CAPTURE ignored.
//  - rst mid-capture: full return to reset state; a held claim is lost.
// STRUCTURE
//  - sdma_pkg: typedef enum {IDLE, WAIT_TRIG, CAPTURE, SWAP} cap_state_t; trig_mode_t enum;
//    ADDR_W/IDX_W localparam helpers.
//  - Sub-module sdma_bank_ram: simple dual-port RAM, 2*DEPTH x DATA_WIDTH, bank bit as address MSB,
//    registered read; one instance per channel (generate loop). Top holds the FSM, pointers and ownership logic.
// TESTING  (bench: DATA_WIDTH=12, DEPTH=16, CHANNELS=2)
//  1 arm, mode 1, ch0=i, ch1=100+i on sample_en every 3 clk, rising trig_in -> after 16 samples
//    buf_ready=1, frame_id=1; claim, then reads of addr 0..15 give 0..15 and addr 16..31 give 100..115.
//  2 Mode 1 with only a falling edge -> stays WAIT_TRIG, capturing=0; mode 3 with a falling edge -> captures.
//  3 Claim held across 2 further frames -> overrun_cnt=2, frame_id=1, read data unchanged;
//    release -> next frame swaps, frame_id=2.
//  4 host_release on the exact SWAP cycle -> swap occurs, buf_ready=1, overrun_cnt unchanged.
//  5 abort at sample 7 -> IDLE, ptr 0, frame_id/buf_ready unchanged; re-arm captures a full frame.
//  6 rst asserted mid-CAPTURE with claimed=1 -> next cycle all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/sdma_pkg.sv
// Shared types and helpers for the multi-channel ping-pong capture block.
package sdma_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    SWAP      = 2'd3
  } cap_state_t;

  // Trigger qualification modes, as driven on trig_mode.
  typedef enum logic [1:0] {
    TRIG_FREE = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_FALL = 2'd2,
    TRIG_BOTH = 2'd3
  } trig_mode_t;

  // Width of the frame ID and overrun counters.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  // Sample index width inside one channel of one bank.
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Channel-select bits in the read address (0 for a single channel).
  function automatic int ch_bits(input int channels);
    return $clog2(channels);
  endfunction

  // Full read-address width: {channel, sample index}.
  function automatic int addr_w(input int channels, input int depth);
    return ch_bits(channels) + idx_w(depth);
  endfunction

  // Decides whether the current trig_in sample, relative to the previous
  // one, starts a capture in the given mode. Free-run always qualifies.
  function automatic logic trig_hit(input trig_mode_t mode, input logic cur, input logic prev);
    logic hit;
    case (mode)
      TRIG_FREE: hit = 1'b1;
      TRIG_RISE: hit = cur & ~prev;
      TRIG_FALL: hit = ~cur & prev;
      TRIG_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Saturating increment for the overrun counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdma_bank_ram.sv
// One channel's ping-pong storage: 2*DEPTH words, bank select is the
// address MSB. Single write port, single registered read port.
module sdma_bank_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [$clog2(DEPTH):0]    waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      re_i,
  input  logic [$clog2(DEPTH):0]    raddr_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:2*DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port; contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; only the output register is cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdma_mc_capture.sv
// Multi-channel triggered ping-pong capture buffer. Fills the write bank
// with DEPTH samples per channel, then swaps banks so the host can read a
// stable frame. Handles trigger modes, host claim/release, overrun
// counting, frame IDs and abort.
module sdma_mc_capture
  import sdma_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int CHANNELS   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sample_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0]          adc_data,
  input  logic                                    trig_in,
  input  logic [1:0]                              trig_mode,
  input  logic                                    arm,
  input  logic                                    abort,
  input  logic                                    host_claim,
  input  logic                                    host_release,
  input  logic                                    rd_en,
  input  logic [$clog2(CHANNELS)+$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]                   rd_data,
  output logic                                    rd_valid,
  output logic                                    buf_ready,
  output logic                                    claimed,
  output logic                                    capturing,
  output logic [15:0]                             frame_id,
  output logic [15:0]                             overrun_cnt
);

  localparam int IDX_W   = idx_w(DEPTH);
  localparam int CH_BITS = ch_bits(CHANNELS);
  localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int ADDR_W  = addr_w(CHANNELS, DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  cap_state_t            state_q, state_d;
  trig_mode_t            mode_q, mode_d;
  logic                  trig_prev_q;
  logic                  wbank_q, wbank_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  buf_ready_q, buf_ready_d;
  logic                  claimed_q, claimed_d;
  logic [CNT_W-1:0]      frame_id_q, frame_id_d;
  logic [CNT_W-1:0]      overrun_q, overrun_d;
  logic                  capturing_q;
  logic                  rd_valid_q;
  logic [CH_W-1:0]       rd_ch_q;

  logic                  we_s;
  logic                  rel_s;
  logic                  clm_s;
  logic                  claimed_eff_s;
  logic                  ready_eff_s;
  logic [CH_W-1:0]       rd_ch_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s [CHANNELS];
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Ownership requests are qualified against the current state; a release
  // is applied before any swap decision in the same cycle, and a claim
  // taken in a SWAP cycle makes that swap be refused.
  assign rel_s         = host_release & claimed_q;
  assign clm_s         = host_claim & buf_ready_q & ~claimed_q;
  assign claimed_eff_s = (claimed_q & ~rel_s) | clm_s;
  assign ready_eff_s   = buf_ready_q & ~rel_s;

  // Split the read address into channel and sample index.
  generate
    if (CH_BITS > 0) begin : g_multi_ch
      assign rd_ch_s = rd_addr[ADDR_W-1 -: CH_W];
    end else begin : g_single_ch
      assign rd_ch_s = {CH_W{1'b0}};
    end
  endgenerate
  assign rd_idx_s = rd_addr[IDX_W-1:0];

  // Next-state logic for the capture FSM, bank pointer and ownership.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wbank_d     = wbank_q;
    ptr_d       = ptr_q;
    frame_id_d  = frame_id_q;
    overrun_d   = overrun_q;
    claimed_d   = claimed_eff_s;
    buf_ready_d = ready_eff_s;
    we_s        = 1'b0;
    if (abort) begin
      // Partial frame is dropped silently; ownership and read bank stay.
      state_d = IDLE;
      ptr_d   = {IDX_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            mode_d  = trig_mode_t'(trig_mode);
            state_d = (trig_mode_t'(trig_mode) == TRIG_FREE) ? CAPTURE : WAIT_TRIG;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_TRIG: begin
          if (trig_hit(mode_q, trig_in, trig_prev_q)) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT_TRIG;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            we_s = 1'b1;
            if (ptr_q == LAST_IDX) begin
              ptr_d   = {IDX_W{1'b0}};
              state_d = SWAP;
            end else begin
              ptr_d = ptr_q + IDX_W'(1);
            end
          end else begin
            we_s = 1'b0;
          end
        end
        SWAP: begin
          mode_d  = trig_mode_t'(trig_mode);
          state_d = (trig_mode_t'(trig_mode) == TRIG_FREE) ? CAPTURE : WAIT_TRIG;
          if (!claimed_eff_s) begin
            // Publish the fresh frame; an unread one it replaces is lost.
            wbank_d     = ~wbank_q;
            frame_id_d  = frame_id_q + 16'd1;
            buf_ready_d = 1'b1;
            overrun_d   = ready_eff_s ? sat_inc(overrun_q) : overrun_q;
          end else begin
            // Host holds the read bank: the new frame is discarded.
            overrun_d = sat_inc(overrun_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, pointer, ownership and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= TRIG_FREE;
      trig_prev_q <= 1'b0;
      wbank_q     <= 1'b0;
      ptr_q       <= {IDX_W{1'b0}};
      buf_ready_q <= 1'b0;
      claimed_q   <= 1'b0;
      frame_id_q  <= 16'd0;
      overrun_q   <= 16'd0;
      capturing_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trig_prev_q <= trig_in;
      wbank_q     <= wbank_d;
      ptr_q       <= ptr_d;
      buf_ready_q <= buf_ready_d;
      claimed_q   <= claimed_d;
      frame_id_q  <= frame_id_d;
      overrun_q   <= overrun_d;
      capturing_q <= (state_d == CAPTURE);
    end
  end

  // Read-side registers: valid flag and the channel selected by the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_ch_q    <= {CH_W{1'b0}};
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_ch_q <= rd_ch_s;
      end
    end
  end

  // Per-channel bank RAMs; write side follows the write bank, read side the other.
  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sdma_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we_s),
        .waddr_i ({wbank_q, ptr_q}),
        .wdata_i (adc_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .re_i    (rd_en),
        .raddr_i ({~wbank_q, rd_idx_s}),
        .rdata_o (ram_rdata_s[c])
      );
    end
  endgenerate

  // Select the registered RAM word of the requested channel; channels
  // beyond CHANNELS match nothing and read as zero.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      rd_data_s = (rd_ch_q == CH_W'(c)) ? ram_rdata_s[c] : rd_data_s;
    end
  end

  assign rd_data     = rd_data_s;
  assign rd_valid    = rd_valid_q;
  assign buf_ready   = buf_ready_q;
  assign claimed     = claimed_q;
  assign capturing   = capturing_q;
  assign frame_id    = frame_id_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_sdma_mc_capture.sv
// Directed bench for sdma_mc_capture (DATA_WIDTH=12, DEPTH=16, CHANNELS=2)
// with a frame-level reference model checked every cycle.
module tb_sdma_mc_capture;

  localparam int DW  = 12;
  localparam int DEP = 16;
  localparam int CH  = 2;
  localparam int AW  = 5;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_CAP  = 2;
  localparam int P_SWAP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              sample_en;
  logic [CH*DW-1:0]  adc_data;
  logic              trig_in;
  logic [1:0]        trig_mode;
  logic              arm;
  logic              abort;
  logic              host_claim;
  logic              host_release;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              buf_ready;
  logic              claimed;
  logic              capturing;
  logic [15:0]       frame_id;
  logic [15:0]       overrun_cnt;

  int checks   = 0;
  int failures = 0;

  sdma_mc_capture #(.DATA_WIDTH(DW), .DEPTH(DEP), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .adc_data     (adc_data),
    .trig_in      (trig_in),
    .trig_mode    (trig_mode),
    .arm          (arm),
    .abort        (abort),
    .host_claim   (host_claim),
    .host_release (host_release),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .buf_ready    (buf_ready),
    .claimed      (claimed),
    .capturing    (capturing),
    .frame_id     (frame_id),
    .overrun_cnt  (overrun_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase, m_mode, m_cnt, m_wbank, m_fid, m_ovr, m_rdata;
  bit m_ready, m_claimed, m_prev, m_rdv, m_rdknown;
  int m_mem   [2][CH][DEP];
  bit m_known [2][CH][DEP];

  task automatic model_step();
    bit rel, clm, cl_n, rdy_n, hit;
    int ch, idx;
    if (rst) begin
      m_phase = P_IDLE; m_mode = 0; m_cnt = 0; m_wbank = 0;
      m_fid = 0; m_ovr = 0; m_ready = 0; m_claimed = 0; m_prev = 0;
      m_rdv = 0; m_rdata = 0; m_rdknown = 1;
      return;
    end
    if (rd_en) begin
      ch  = int'(rd_addr[4]);
      idx = int'(rd_addr[3:0]);
      m_rdata   = m_mem[1 - m_wbank][ch][idx];
      m_rdknown = m_known[1 - m_wbank][ch][idx];
    end
    m_rdv = rd_en;
    rel   = host_release && m_claimed;
    clm   = host_claim && m_ready && !m_claimed;
    cl_n  = (m_claimed && !rel) || clm;
    rdy_n = m_ready && !rel;
    if (abort) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
    end else if (m_phase == P_IDLE) begin
      if (arm) begin
        m_mode  = int'(trig_mode);
        m_phase = (m_mode == 0) ? P_CAP : P_WAIT;
      end
    end else if (m_phase == P_WAIT) begin
      case (m_mode)
        0: hit = 1;
        1: hit = trig_in && !m_prev;
        2: hit = !trig_in && m_prev;
        default: hit = (trig_in != m_prev);
      endcase
      if (hit) m_phase = P_CAP;
    end else if (m_phase == P_CAP) begin
      if (sample_en) begin
        for (int c = 0; c < CH; c++) begin
          m_mem[m_wbank][c][m_cnt]   = int'(adc_data[c*DW +: DW]);
          m_known[m_wbank][c][m_cnt] = 1;
        end
        if (m_cnt == DEP - 1) begin
          m_cnt   = 0;
          m_phase = P_SWAP;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      if (!cl_n) begin
        m_wbank = 1 - m_wbank;
        m_fid   = (m_fid + 1) % 65536;
        if (rdy_n && m_ovr < 65535) m_ovr++;
        rdy_n = 1;
      end else if (m_ovr < 65535) begin
        m_ovr++;
      end
      m_mode  = int'(trig_mode);
      m_phase = (m_mode == 0) ? P_CAP : P_WAIT;
    end
    m_prev    = trig_in;
    m_claimed = cl_n;
    m_ready   = rdy_n;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #4;
      chk("buf_ready",   buf_ready,   m_ready);
      chk("claimed",     claimed,     m_claimed);
      chk("capturing",   capturing,   m_phase == P_CAP);
      chk("frame_id",    frame_id,    m_fid);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      chk("rd_valid",    rd_valid,    m_rdv);
      if (m_rdknown) chk("rd_data", rd_data, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // n samples, one every 3 clocks: ch0 = b0+i, ch1 = b1+i. Optionally
  // pulses host_release in the cycle right after the last sample (SWAP).
  task automatic samples(input int n, input int b0, input int b1, input bit rel_on_swap);
    for (int i = 0; i < n; i++) begin
      adc_data  = {12'(b1 + i), 12'(b0 + i)};
      sample_en = 1'b1;
      cyc();
      sample_en = 1'b0;
      if (rel_on_swap && i == n - 1) host_release = 1'b1;
      cyc();
      host_release = 1'b0;
      cyc();
    end
  endtask

  task automatic rd_chk(input string name, input int addr, input int exp);
    rd_en   = 1'b1;
    rd_addr = 5'(addr);
    cyc();
    rd_en = 1'b0;
    chk(name, rd_data, exp);
    chk({name, "_v"}, rd_valid, 1);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; adc_data = 24'd0; trig_in = 1'b0;
    trig_mode = 2'd0; arm = 1'b0; abort = 1'b0; host_claim = 1'b0;
    host_release = 1'b0; rd_en = 1'b0; rd_addr = 5'd0;
    cyc(); cyc();
    chk("rst_buf_ready", buf_ready, 0);
    chk("rst_claimed",   claimed,   0);
    chk("rst_capturing", capturing, 0);
    chk("rst_frame_id",  frame_id,  0);
    chk("rst_overrun",   overrun_cnt, 0);
    chk("rst_rd_data",   rd_data,   0);
    rst = 1'b0;
    cyc();

    // 1: rising-edge capture, claim, full readback
    trig_mode = 2'd1; arm = 1'b1; cyc(); arm = 1'b0;
    chk("t1_wait_nocap", capturing, 0);
    trig_in = 1'b1; cyc();
    chk("t1_capturing", capturing, 1);
    samples(16, 0, 100, 1'b0);
    chk("t1_ready", buf_ready, 1);
    chk("t1_fid", frame_id, 1);
    chk("t1_ovr", overrun_cnt, 0);
    host_claim = 1'b1; cyc(); host_claim = 1'b0;
    chk("t1_claimed", claimed, 1);
    for (int a = 0; a < 32; a++) rd_chk("t1_rd", a, (a < 16) ? a : 100 + a - 16);

    // 2: falling edge ignored in rising mode; captured in both-edge mode
    trig_in = 1'b0; cyc(); cyc(); cyc();
    chk("t2_fall_ignored", capturing, 0);
    abort = 1'b1; cyc(); abort = 1'b0;
    trig_in = 1'b1; cyc();
    trig_mode = 2'd3; arm = 1'b1; cyc(); arm = 1'b0;
    trig_in = 1'b0; cyc();
    chk("t2_both_fall", capturing, 1);

    // 3: claim held across two frames
    samples(16, 200, 300, 1'b0);
    trig_in = 1'b1; cyc();
    samples(16, 210, 310, 1'b0);
    chk("t3_ovr", overrun_cnt, 2);
    chk("t3_fid", frame_id, 1);
    rd_chk("t3_rd0", 0, 0);
    rd_chk("t3_rd5", 5, 5);
    rd_chk("t3_rd16", 16, 100);
    rd_chk("t3_rd31", 31, 115);
    host_release = 1'b1; cyc(); host_release = 1'b0;
    chk("t3_rel_claimed", claimed, 0);
    chk("t3_rel_ready", buf_ready, 0);
    trig_in = 1'b0; cyc();
    samples(16, 20, 40, 1'b0);
    chk("t3_fid2", frame_id, 2);
    chk("t3_ovr_keep", overrun_cnt, 2);
    rd_chk("t3_rd3", 3, 23);
    rd_chk("t3_rd19", 19, 43);

    // 4: release in the SWAP cycle
    host_claim = 1'b1; cyc(); host_claim = 1'b0;
    trig_in = 1'b1; cyc();
    samples(16, 7, 9, 1'b1);
    chk("t4_fid", frame_id, 3);
    chk("t4_ready", buf_ready, 1);
    chk("t4_claimed", claimed, 0);
    chk("t4_ovr", overrun_cnt, 2);

    // 5: abort mid-frame, re-arm
    trig_in = 1'b0; cyc();
    samples(7, 50, 51, 1'b0);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_idle", capturing, 0);
    chk("t5_fid", frame_id, 3);
    chk("t5_ready", buf_ready, 1);
    trig_mode = 2'd1; arm = 1'b1; cyc(); arm = 1'b0;
    trig_in = 1'b1; cyc();
    samples(16, 60, 80, 1'b0);
    chk("t5_fid4", frame_id, 4);
    chk("t5_ovr", overrun_cnt, 3);
    rd_chk("t5_rd0", 0, 60);
    rd_chk("t5_rd15", 15, 75);
    rd_chk("t5_rd16", 16, 80);
    rd_chk("t5_rd31", 31, 95);

    // 6: reset mid-capture with claim held
    host_claim = 1'b1; cyc(); host_claim = 1'b0;
    chk("t6_claimed", claimed, 1);
    trig_in = 1'b0; cyc();
    trig_in = 1'b1; cyc();
    chk("t6_capturing", capturing, 1);
    samples(3, 1, 2, 1'b0);
    rst = 1'b1; cyc();
    chk("t6_ready", buf_ready, 0);
    chk("t6_claimed0", claimed, 0);
    chk("t6_capturing0", capturing, 0);
    chk("t6_fid", frame_id, 0);
    chk("t6_ovr", overrun_cnt, 0);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_data", rd_data, 0);
    rst = 1'b0;
    cyc(); cyc();
    chk("t6_idle", capturing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
